// File: rtl/keccak_pkg.sv
// Shared types and helpers for the keccak message packer.
// Lane 0 is the most significant byte of the word handed to the core.
package keccak_pkg;

    typedef enum logic [1:0] {
        ACCUM      = 2'd0,
        EMIT       = 2'd1,
        EMIT_LAST  = 2'd2,
        EMIT_EMPTY = 2'd3
    } pk_state_t;

    localparam int BYTE_W = 8;

    // Bit offset of the byte lane selected by idx; lane 0 sits at the top.
    function automatic int lane_off(input int bpw, input int idx);
        return BYTE_W * (bpw - 1 - idx);
    endfunction

endpackage

// File: rtl/keccak_msg_packer.sv
// Packs a framed byte stream into BYTES_PER_WORD-wide words for the keccak core,
// always closing a message with a word that has is_last=1 (possibly empty).
module keccak_msg_packer
    import keccak_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16,
    localparam int BN_W          = $clog2(BYTES_PER_WORD)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    input  logic                          s_empty,
    output logic                          s_ready,
    output logic [8*BYTES_PER_WORD-1:0]   in,
    output logic                          in_ready,
    output logic                          is_last,
    output logic [BN_W-1:0]               byte_num,
    input  logic                          buffer_full,
    output logic [CNT_W-1:0]              msg_bytes,
    output logic                          msg_done
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;

    pk_state_t          state_q, state_d;
    logic [BN_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               pend_q, pend_d;
    logic               last_q, last_d;
    logic [BN_W-1:0]    bn_q, bn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               done_q, done_d;
    logic               accept;
    logic               emitting;

    // s_ready is forced low while reset is held, independent of state.
    assign s_ready  = reset && (state_q == ACCUM);
    assign accept   = s_valid && s_ready;
    assign emitting = (state_q != ACCUM);
    assign in_ready = emitting && !buffer_full;

    assign in        = word_q;
    assign is_last   = last_q;
    assign byte_num  = bn_q;
    assign msg_bytes = cnt_q;
    assign msg_done  = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            word_q  <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            bn_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            bn_q    <= bn_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        pend_d  = pend_q;
        last_d  = last_q;
        bn_d    = bn_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        done_d  = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (s_last && s_empty) begin
                        // Empty close: no byte written; a mid-word s_empty closes the partial word.
                        last_d = 1'b1;
                        if (idx_q == '0) begin
                            state_d = EMIT_EMPTY;
                            bn_d    = '0;
                            if (first_q) cnt_d = '0;
                        end else begin
                            state_d = EMIT_LAST;
                            bn_d    = idx_q;
                        end
                    end else begin
                        word_d[lane_off(BYTES_PER_WORD, int'(idx_q)) +: BYTE_W] = s_data;
                        idx_d   = idx_q + BN_W'(1);
                        first_d = 1'b0;
                        if (first_q)      cnt_d = CNT_W'(1);
                        else if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                        if (idx_q == BN_W'(BYTES_PER_WORD - 1)) begin
                            state_d = EMIT;
                            pend_d  = s_last;
                            last_d  = 1'b0;
                            bn_d    = '0;
                        end else if (s_last) begin
                            state_d = EMIT_LAST;
                            last_d  = 1'b1;
                            bn_d    = idx_q + BN_W'(1);
                        end
                    end
                end
            end

            EMIT: begin
                if (!buffer_full) begin
                    word_d = '0;
                    idx_d  = '0;
                    pend_d = 1'b0;
                    if (pend_q) begin
                        // A full final word still needs the empty closing word.
                        state_d = EMIT_EMPTY;
                        last_d  = 1'b1;
                        bn_d    = '0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            EMIT_LAST, EMIT_EMPTY: begin
                if (!buffer_full) begin
                    state_d = ACCUM;
                    word_d  = '0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    bn_d    = '0;
                    first_d = 1'b1;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ACCUM;
        endcase
    end

endmodule

// File: doc/keccak_msg_packer.md
Name: keccak_msg_packer

Overview:
Synthesizable replacement for the testbench byte-feeding task in front of the keccak core. Accepts a byte stream with valid/ready/last framing and packs it into BYTES_PER_WORD-wide words. Drives the core's in/in_ready/is_last/byte_num interface and obeys buffer_full back-pressure. Generalised over word width, with message-length tracking, zero-length message support and the mandatory empty closing word.

Parameters:
BYTES_PER_WORD, 4, bytes per output word; power of two, 2..16.
BN_W, $clog2(BYTES_PER_WORD), width of byte_num; derived, not overridden.
CNT_W, 16, width of the message byte counter.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset (reset==0 resets).
s_data  input  8  upstream byte.
s_valid  input  1  upstream byte valid.
s_last  input  1  byte is the final byte of the message.
s_empty  input  1  qualifies s_last: zero-length message, s_data ignored; legal only with s_last=1.
s_ready  output  1  packer accepts the byte this cycle.
in  output  8*BYTES_PER_WORD  word to the core; first byte in the MS lane.
in_ready  output  1  word valid to the core, single-cycle pulse.
is_last  output  1  final word of the message.
byte_num  output  BN_W  valid bytes in the final word, 0..BYTES_PER_WORD-1.
buffer_full  input  1  core cannot take a word this cycle.
msg_bytes  output  CNT_W  byte count of the current or most recent message; saturates.
msg_done  output  1  one-cycle pulse when the final word is issued.

Behaviour:
- Reset values: s_ready=0 while reset is asserted, 1 from the first cycle in ACCUM. in=0, in_ready=0, is_last=0, byte_num=0, msg_bytes=0, msg_done=0. State=ACCUM; lane index=0.
- States: ACCUM, EMIT, EMIT_LAST, EMIT_EMPTY.
- ACCUM: s_ready=1. A byte is accepted when s_valid && s_ready.
  - The byte is written to lane idx, where lane 0 is bits [8*BPW-1 : 8*BPW-8]. idx then increments.
  - Word becomes full (idx was BPW-1): go to EMIT; latch pend_last=s_last.
  - s_last with a partial word: go to EMIT_LAST; byte_num=idx+1; unfilled lanes are zero.
  - s_last && s_empty with idx==0: go to EMIT_EMPTY; no byte is counted.
  - s_empty with idx!=0 is a protocol error. Treat it as a plain s_last without writing a byte (EMIT_LAST with the current partial word).
- EMIT, EMIT_LAST, EMIT_EMPTY: s_ready=0. in, is_last and byte_num are registered and stable for the whole state.
  - in_ready = !buffer_full, combinational; the handshake completes in the cycle in_ready=1.
  - EMIT: is_last=0. After the handshake: pend_last ? EMIT_EMPTY : ACCUM.
  - EMIT_LAST: is_last=1. After the handshake: ACCUM.
  - EMIT_EMPTY: in=0, is_last=1, byte_num=0. After the handshake: ACCUM.
  - After the EMIT_LAST or EMIT_EMPTY handshake: msg_done pulses in the following cycle; the lane register and idx clear.
- Latency: the byte that completes a word, accepted in cycle t, gives in_ready at t+1 at the earliest. Throughput is at most BPW bytes per BPW+1 cycles.
- buffer_full held high: the state holds indefinitely, in_ready=0 and s_ready=0. No word is dropped or duplicated.
- msg_bytes:
  - Loads 1 on the first accepted byte of a message, otherwise increments per byte.
  - Saturates at 2^CNT_W-1.
  - Loads 0 on an s_empty message.
  - Holds after msg_done until the next message starts.
- Reset asserted mid-message: the partial word and pending words are discarded and all outputs return to reset values immediately. The next message starts clean.

Decomposition:
- Package keccak_pkg holds:
  - the state enum pk_state_t {ACCUM, EMIT, EMIT_LAST, EMIT_EMPTY};
  - localparam BYTE_W=8;
  - a function computing the lane bit offset from idx.
- No sub-module. Lane write, FSM and counter stay in one module, about 150-200 lines.

Test Plan:
- "Vik" (3 bytes), BPW=4 -> one in_ready pulse: in=0x56696B00, is_last=1, byte_num=3; msg_bytes=3; one msg_done.
- "abcd" -> pulse 1: in=0x61626364, is_last=0. Pulse 2: in=0, is_last=1, byte_num=0. msg_bytes=4.
- Single s_valid with s_last=1, s_empty=1 -> one pulse: in=0, is_last=1, byte_num=0; msg_bytes=0.
- "abcd" with buffer_full=1 for 5 cycles after the 4th byte -> in_ready=0 and s_ready=0 for 5 cycles, then exactly one pulse with in=0x61626364; no byte is lost.
- 43-byte sentence, BPW=4 -> 10 words with is_last=0, then a final word with is_last=1, byte_num=3; msg_bytes=43.
- BPW=8 with "Vik" -> in=0x56696B0000000000, byte_num=3.
- Reset pulsed after 2 bytes of "abcd", then "Vik" -> outputs return to 0 during reset; afterwards a single word 0x56696B00 with byte_num=3.
